mesi_line_array: RTL
====================

# mesi_line_array

Parametrised MESI coherence state store for the cache simulator: holds one MESI state per cache line for `NUM_LINES` lines and processes one coherence event per cycle (CPU read/write, bus snoops, evict, flush-all). For each event it reports the old and new line state, the bus operation this cache must issue, and the snoop result it must put on the bus. Replaces the single-line, fixed-encoding MESI FSM with an indexed array, a handshake and a multi-cycle flush.

## Interface
- `NUM_LINES`, 16, number of tracked lines; power of two, ≥ 2
- `IDX_W`, `$clog2(NUM_LINES)`, line index width (derived, not overridden)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted on edge where `req_valid && req_ready`
- `req_op`  in  3  `op_t` event code
- `req_idx`  in  IDX_W  target line (ignored for FLUSH)
- `snoop_in`  in  2  `snoop_res_t` from other caches, sampled with CPU_READ only
- `rsp_valid`  out  1  response strobe, one cycle, no backpressure
- `rsp_idx`  out  IDX_W  line the response refers to
- `rsp_old`  out  2  `mesi_t` state before event
- `rsp_new`  out  2  `mesi_t` state after event
- `bus_op`  out  3  `bus_op_t` this cache must issue
- `snoop_out`  out  2  `snoop_res_t` this cache drives for snoop events, NOHIT otherwise
- `mod_count`  out  IDX_W+1  number of lines currently in M

## Operation
- Encodings: mesi_t I=0, S=1, E=2, M=3; op_t CPU_READ=0, CPU_WRITE=1, SNP_READ=2, SNP_WRITE=3, SNP_RFO=4, SNP_INV=5, EVICT=6, FLUSH=7; bus_op_t NONE=0, READ=1, WRITE=2, INVAL=3, RWIM=4; snoop_res_t NOHIT=0, HIT=1, HITM=2.
- CPU_READ: I → READ, new E if `snoop_in`=NOHIT else S; S/E/M unchanged, NONE.
- CPU_WRITE: I → RWIM, M; S → INVAL, M; E → M, NONE; M unchanged.
- SNP_READ: I → NOHIT; S, E → HIT, S; M → HITM, S, bus WRITE.
- SNP_WRITE: no state change, NOHIT, NONE.
- SNP_RFO: I → NOHIT; S, E → HIT, I; M → HITM, I, bus WRITE.
- SNP_INV: S → HIT, I; I/E/M unchanged, NOHIT.
- EVICT: M → WRITE, I; all others → I, NONE.
- FLUSH: visits lines 0..N-1 in order, one per cycle; each line evicted (M → WRITE, I); one response per line.
- Control FSM: IDLE (`req_ready`=1), FLUSHING (`req_ready`=0, line counter `cnt`). IDLE + accepted FLUSH → FLUSHING, cnt=1; FLUSHING with cnt=N-1 → IDLE after processing; else cnt+1.
- `mod_count` tracks M entries: +1 on any transition into M, −1 on any out of M, same edge as state update; never wraps (0..NUM_LINES).
- Reset: all lines I, FSM IDLE, cnt=0, `rsp_valid`=0, `rsp_idx`/`rsp_old`/`rsp_new`/`bus_op`/`snoop_out`=0, `mod_count`=0. `req_ready` is 1 in the first cycle after reset. Reset mid-flush aborts the flush; no further responses.

## Timing
- Single-line ops: accepted at edge ending cycle T; array updated at that edge; response fields valid during cycle T+1 only. Back-to-back ops accepted every cycle; op in cycle T+1 to the same line sees the state written at end of T.
- FLUSH accepted in cycle 0: line k processed at edge ending cycle k, its response in cycle k+1; `req_ready`=0 cycles 1..N-1, 1 again in cycle N; a request accepted in cycle N responds in cycle N+1.
- `rsp_valid`=0 in cycles with no accepted request and no flush step.
- `mod_count` is registered; reflects the update one cycle after acceptance, coincident with `rsp_valid`.

## Structure
- Package `mesi_pkg`: `mesi_t`, `op_t`, `bus_op_t`, `snoop_res_t` typedefs and encodings; shared with trace parser and stats blocks.
- Sub-module `mesi_next_state` (combinational): inputs op, current state, `snoop_in`; outputs next state, bus_op, snoop_out. Top holds array, FSM, counter and response registers.

## Test plan
- Reset, CPU_READ idx 3 with `snoop_in`=NOHIT → cycle+1: old I, new E, bus READ; CPU_WRITE idx 3 → old E, new M, NONE, `mod_count`=1.
- CPU_READ idx 5 `snoop_in`=HIT → S; CPU_WRITE idx 5 → INVAL, M; SNP_READ idx 5 → HITM, bus WRITE, new S, `mod_count` back to 0.
- SNP_RFO on I, S, E, M lines → NOHIT/HIT/HIT/HITM, all new I, WRITE only for M.
- Lines 0 and 7 in M, FLUSH (N=16) → 16 responses idx 0..15 in consecutive cycles, WRITE on idx 0 and 7 only, `req_ready` low cycles 1..15, `mod_count`=0 at end.
- Assert reset during flush at step 4 → no further `rsp_valid`, all lines I, `req_ready`=1 next cycle.
- Back-to-back CPU_WRITE then SNP_INV on same S line, then SNP_WRITE → INVAL/M, then NOHIT unchanged M, then NOHIT unchanged.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared MESI coherence encodings: line state, event code, bus operation, snoop result.
package mesi_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        OP_CPU_READ  = 3'd0,
        OP_CPU_WRITE = 3'd1,
        OP_SNP_READ  = 3'd2,
        OP_SNP_WRITE = 3'd3,
        OP_SNP_RFO   = 3'd4,
        OP_SNP_INV   = 3'd5,
        OP_EVICT     = 3'd6,
        OP_FLUSH     = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        BUS_NONE  = 3'd0,
        BUS_READ  = 3'd1,
        BUS_WRITE = 3'd2,
        BUS_INVAL = 3'd3,
        BUS_RWIM  = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SR_NOHIT = 2'd0,
        SR_HIT   = 2'd1,
        SR_HITM  = 2'd2
    } snoop_res_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_FLUSHING = 1'b1
    } ctrl_t;

endpackage

// File: rtl/mesi_line_array_if.sv
// Request/response bundle between a coherence event source and the MESI line array.
interface mesi_line_array_if
    import mesi_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16
);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);

    logic             req_valid;
    logic             req_ready;
    op_t              req_op;
    logic [IDX_W-1:0] req_idx;
    snoop_res_t       snoop_in;
    logic             rsp_valid;
    logic [IDX_W-1:0] rsp_idx;
    mesi_t            rsp_old;
    mesi_t            rsp_new;
    bus_op_t          bus_op;
    snoop_res_t       snoop_out;
    logic [IDX_W:0]   mod_count;

    modport master (
        output req_valid, req_op, req_idx, snoop_in,
        input  req_ready, rsp_valid, rsp_idx, rsp_old, rsp_new, bus_op, snoop_out, mod_count
    );

    modport slave (
        input  req_valid, req_op, req_idx, snoop_in,
        output req_ready, rsp_valid, rsp_idx, rsp_old, rsp_new, bus_op, snoop_out, mod_count
    );

endinterface

// File: rtl/mesi_next_state.sv
// Combinational MESI transition table: next state, bus operation and snoop reply for one event.
module mesi_next_state
    import mesi_pkg::*;
(
    input  op_t        op,
    input  mesi_t      cur,
    input  snoop_res_t snoop_in,
    output mesi_t      nxt,
    output bus_op_t    bus_op,
    output snoop_res_t snoop_out
);

    always_comb begin
        nxt       = cur;
        bus_op    = BUS_NONE;
        snoop_out = SR_NOHIT;
        case (op)
            OP_CPU_READ: begin
                if (cur == MESI_I) begin
                    bus_op = BUS_READ;
                    nxt    = (snoop_in == SR_NOHIT) ? MESI_E : MESI_S;
                end
            end
            OP_CPU_WRITE: begin
                nxt = MESI_M;
                case (cur)
                    MESI_I:  bus_op = BUS_RWIM;
                    MESI_S:  bus_op = BUS_INVAL;
                    default: bus_op = BUS_NONE;
                endcase
            end
            OP_SNP_READ, OP_SNP_RFO: begin
                if (cur != MESI_I) begin
                    nxt = (op == OP_SNP_READ) ? MESI_S : MESI_I;
                    if (cur == MESI_M) begin
                        snoop_out = SR_HITM;
                        bus_op    = BUS_WRITE;
                    end else begin
                        snoop_out = SR_HIT;
                    end
                end
            end
            OP_SNP_INV: begin
                if (cur == MESI_S) begin
                    snoop_out = SR_HIT;
                    nxt       = MESI_I;
                end
            end
            // a flush step is an evict of the visited line
            OP_EVICT, OP_FLUSH: begin
                nxt = MESI_I;
                if (cur == MESI_M) bus_op = BUS_WRITE;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mesi_line_array.sv
// Indexed MESI state store: one coherence event per cycle, registered response, multi-cycle flush.
module mesi_line_array
    import mesi_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16
) (
    input logic              clk,
    input logic              reset,
    mesi_line_array_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned CNT_W = IDX_W + 1;

    mesi_t            lines [NUM_LINES];
    ctrl_t            state, state_nxt;
    logic [IDX_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] step_idx;
    op_t              step_op;
    logic             step;
    mesi_t            cur, nxt;
    bus_op_t          nxt_bus;
    snoop_res_t       nxt_snoop;
    logic [CNT_W-1:0] mod_q, mod_nxt;

    logic             rsp_valid_q;
    logic [IDX_W-1:0] rsp_idx_q;
    mesi_t            rsp_old_q, rsp_new_q;
    bus_op_t          bus_op_q;
    snoop_res_t       snoop_out_q;

    // Control FSM: choose which line/event is processed this cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step      = 1'b0;
        step_idx  = bus.req_idx;
        step_op   = bus.req_op;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    step = 1'b1;
                    if (bus.req_op == OP_FLUSH) begin
                        step_idx  = '0;
                        step_op   = OP_EVICT;
                        state_nxt = ST_FLUSHING;
                        cnt_nxt   = IDX_W'(1);
                    end
                end
            end
            ST_FLUSHING: begin
                step     = 1'b1;
                step_idx = cnt;
                step_op  = OP_EVICT;
                if (cnt == IDX_W'(NUM_LINES - 1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + IDX_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cur = lines[step_idx];

    mesi_next_state u_next (
        .op        (step_op),
        .cur       (cur),
        .snoop_in  (bus.snoop_in),
        .nxt       (nxt),
        .bus_op    (nxt_bus),
        .snoop_out (nxt_snoop)
    );

    always_comb begin
        mod_nxt = mod_q;
        if (step && nxt == MESI_M && cur != MESI_M) begin
            mod_nxt = mod_q + CNT_W'(1);
        end else if (step && cur == MESI_M && nxt != MESI_M) begin
            mod_nxt = mod_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            mod_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_old_q   <= MESI_I;
            rsp_new_q   <= MESI_I;
            bus_op_q    <= BUS_NONE;
            snoop_out_q <= SR_NOHIT;
            for (int i = 0; i < NUM_LINES; i++) lines[i] <= MESI_I;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mod_q       <= mod_nxt;
            rsp_valid_q <= step;
            if (step) begin
                lines[step_idx] <= nxt;
                rsp_idx_q       <= step_idx;
                rsp_old_q       <= cur;
                rsp_new_q       <= nxt;
                bus_op_q        <= nxt_bus;
                snoop_out_q     <= nxt_snoop;
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_old   = rsp_old_q;
    assign bus.rsp_new   = rsp_new_q;
    assign bus.bus_op    = bus_op_q;
    assign bus.snoop_out = snoop_out_q;
    assign bus.mod_count = mod_q;

endmodule
